// File: rtl/nx_stream_framer.sv
// nx_stream_framer
//
// Host-side framer for the Nexus outbound control stream. Nexus delivers
// control responses as a bare valid/ready stream with no frame boundaries.
// This block regenerates tlast so the downstream AXI4-stream DMA receives
// bounded frames. A frame closes when it reaches MAX_BEATS beats, when the
// input has been idle for TIMEOUT cycles with a beat pending, or on an
// explicit flush request.
//
// Ports:
//   clk              single clock, rising edge
//   rstn             asynchronous active-low reset
//   inbound_tdata    beat data from Nexus
//   inbound_tvalid   beat valid from Nexus
//   inbound_tready   block accepts the inbound beat (0 while in reset)
//   i_flush          single-cycle request to close the open frame
//   outbound_tdata   beat data to the DMA
//   outbound_tlast   final beat of the frame
//   outbound_tvalid  outbound beat valid
//   outbound_tready  DMA accepts the outbound beat
//   o_idle           hold and output stages both empty
//   o_frame_count    frames completed on outbound, wraps at 16 bits
//
// Structure: a hold stage (H) keeps the most recent beat until we know
// whether it closes the frame; an output stage (O) presents it to the DMA.
// A beat only moves from H to O once a release condition is known, which is
// why tlast can be decided for it.

module nx_stream_framer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int MAX_BEATS       = 16,
  parameter int TIMEOUT         = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXI4_DATA_WIDTH-1:0] inbound_tdata,
  input  logic                       inbound_tvalid,
  output logic                       inbound_tready,
  input  logic                       i_flush,
  output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
  output logic                       outbound_tlast,
  output logic                       outbound_tvalid,
  input  logic                       outbound_tready,
  output logic                       o_idle,
  output logic [15:0]                o_frame_count
);

  localparam int BeatCntW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int IdleCntW = $clog2(TIMEOUT + 1);

  localparam logic [BeatCntW-1:0] BeatLast = BeatCntW'(MAX_BEATS - 1);
  localparam logic [IdleCntW-1:0] IdleMax  = IdleCntW'(TIMEOUT);

  // Hold stage
  logic                       holdValid_q, holdValid_d;
  logic [AXI4_DATA_WIDTH-1:0] holdData_q, holdData_d;

  // Output stage
  logic                       outValid_q, outValid_d;
  logic [AXI4_DATA_WIDTH-1:0] outData_q, outData_d;
  logic                       outLast_q, outLast_d;

  // Frame bookkeeping
  logic [BeatCntW-1:0]        beatCnt_q, beatCnt_d;
  logic [IdleCntW-1:0]        idleCnt_q, idleCnt_d;
  logic [15:0]                frameCnt_q, frameCnt_d;

  // Handshake decode
  logic canLoad;
  logic closeFrame;
  logic releaseHold;
  logic acceptIn;

  // Release decision for the held beat. The close conditions (beat limit,
  // flush, timeout) all produce last=1, so their relative priority only
  // matters against the plain "next beat is arriving" release, which is
  // last=0. Nothing here is latched: if the DMA stalls, the conditions are
  // simply re-evaluated on the cycle O can accept again, so a flush pulse
  // during a stall is lost by design.
  // inbound_tready follows the release so the pipeline sustains one beat per
  // cycle, and is forced low while reset is asserted.
  always_comb begin
    canLoad        = !outValid_q || outbound_tready;
    closeFrame     = (beatCnt_q == BeatLast) || i_flush || (idleCnt_q == IdleMax);
    releaseHold    = holdValid_q && canLoad && (closeFrame || inbound_tvalid);
    inbound_tready = rstn && (!holdValid_q || releaseHold);
    acceptIn       = inbound_tvalid && inbound_tready;
  end

  // Next-state logic for both stages and the counters.
  // The idle counter only runs while a beat is pending and the input is
  // quiet; with H empty there is no open frame, so flush and timeout have
  // nothing to act on. An O beat that is still waiting for the DMA is never
  // touched because O is only reloaded when canLoad is high.
  always_comb begin
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outLast_d   = outLast_q;
    beatCnt_d   = beatCnt_q;
    idleCnt_d   = idleCnt_q;
    frameCnt_d  = frameCnt_q;

    if (acceptIn) begin
      holdValid_d = 1'b1;
      holdData_d  = inbound_tdata;
    end else if (releaseHold) begin
      holdValid_d = 1'b0;
    end

    if (releaseHold) begin
      outValid_d = 1'b1;
      outData_d  = holdData_q;
      outLast_d  = closeFrame;
    end else if (outbound_tready) begin
      outValid_d = 1'b0;
    end

    if (releaseHold) begin
      beatCnt_d = closeFrame ? '0 : beatCnt_q + BeatCntW'(1);
    end

    if (!holdValid_q || inbound_tvalid) begin
      idleCnt_d = '0;
    end else if (idleCnt_q != IdleMax) begin
      idleCnt_d = idleCnt_q + IdleCntW'(1);
    end

    if (outValid_q && outbound_tready && outLast_q) begin
      frameCnt_d = frameCnt_q + 16'd1;
    end
  end

  // State registers. Reset discards both stages at once; any partially
  // built frame is dropped rather than closed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      beatCnt_q   <= '0;
      idleCnt_q   <= '0;
      frameCnt_q  <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outLast_q   <= outLast_d;
      beatCnt_q   <= beatCnt_d;
      idleCnt_q   <= idleCnt_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  assign outbound_tdata  = outData_q;
  assign outbound_tlast  = outLast_q;
  assign outbound_tvalid = outValid_q;
  assign o_idle          = !holdValid_q && !outValid_q;
  assign o_frame_count   = frameCnt_q;

endmodule

// File: tb/tb_nx_stream_framer.sv
// tb_nx_stream_framer
//
// Self-checking bench for nx_stream_framer with MAX_BEATS=4, TIMEOUT=8.
// Inputs are driven on the falling edge; everything is sampled 1 time unit
// before the rising edge. Each accepted inbound beat pushes its expected
// {data,last} into a scoreboard queue; a monitor pops and compares on every
// outbound handshake and also checks that a stalled output beat holds still.

module tb_nx_stream_framer;

  localparam int W  = 128;
  localparam int MB = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] inbound_tdata;
  logic         inbound_tvalid;
  logic         inbound_tready;
  logic         i_flush;
  logic [W-1:0] outbound_tdata;
  logic         outbound_tlast;
  logic         outbound_tvalid;
  logic         outbound_tready;
  logic         o_idle;
  logic [15:0]  o_frame_count;

  beat_t sb[$];
  int    hsCycles[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cycle       = 0;
  int    expFrames   = 0;
  bit    stopRand    = 1'b0;

  nx_stream_framer #(
    .AXI4_DATA_WIDTH(W),
    .MAX_BEATS      (MB),
    .TIMEOUT        (TO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .inbound_tdata  (inbound_tdata),
    .inbound_tvalid (inbound_tvalid),
    .inbound_tready (inbound_tready),
    .i_flush        (i_flush),
    .outbound_tdata (outbound_tdata),
    .outbound_tlast (outbound_tlast),
    .outbound_tvalid(outbound_tvalid),
    .outbound_tready(outbound_tready),
    .o_idle         (o_idle),
    .o_frame_count  (o_frame_count)
  );

  always #5 clk = ~clk;

  // Outbound monitor: scoreboard pop on each handshake, plus AXI stability
  // of a stalled beat.
  initial begin
    logic         prevStall;
    logic [W-1:0] prevData;
    logic         prevLast;
    beat_t        exp;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      cycle++;
      if (rstn !== 1'b1) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          vectors++;
          if (outbound_tvalid !== 1'b1 || outbound_tdata !== prevData || outbound_tlast !== prevLast) begin
            miscompares++;
            $display("[TB] FAIL stall_stability: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                     outbound_tvalid, outbound_tdata, outbound_tlast, prevData, prevLast);
          end
        end
        if (outbound_tvalid === 1'b1 && outbound_tready === 1'b1) begin
          hsCycles.push_back(cycle);
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat: got data=%h last=%0b, want no beat", outbound_tdata, outbound_tlast);
          end else begin
            exp = sb.pop_front();
            if (outbound_tdata !== exp.data || outbound_tlast !== exp.last) begin
              miscompares++;
              $display("[TB] FAIL scoreboard: got data=%h last=%0b, want data=%h last=%0b",
                       outbound_tdata, outbound_tlast, exp.data, exp.last);
            end
          end
        end
        prevStall = (outbound_tvalid === 1'b1) && (outbound_tready !== 1'b1);
        prevData  = outbound_tdata;
        prevLast  = outbound_tlast;
      end
    end
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one beat (optionally with a coincident flush) and hold it until
  // accepted; the expected output is recorded at acceptance.
  task automatic sendBeat(input logic [W-1:0] d, input logic lst, input logic fl);
    bit    ok;
    beat_t b;
    ok = 1'b0;
    @(negedge clk);
    inbound_tdata  = d;
    inbound_tvalid = 1'b1;
    i_flush        = fl;
    for (int t = 0; t < 300; t++) begin
      #4;
      if (inbound_tready === 1'b1) begin
        b.data = d;
        b.last = lst;
        sb.push_back(b);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      i_flush = 1'b0;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got no inbound_tready for data=%h, want acceptance", d);
    end
  endtask

  task automatic idleInput();
    @(negedge clk);
    inbound_tvalid = 1'b0;
    i_flush        = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      #4;
      if (sb.size() == 0 && o_idle === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, o_idle=%0b, want 0 pending and idle", sb.size(), o_idle);
    end
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    inbound_tdata   = '0;
    inbound_tvalid  = 1'b0;
    i_flush         = 1'b0;
    outbound_tready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    vectors++;
    if (outbound_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tvalid: got %0b want 0", outbound_tvalid); end
    vectors++;
    if (outbound_tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tlast: got %0b want 0", outbound_tlast); end
    vectors++;
    if (outbound_tdata !== '0) begin miscompares++; $display("[TB] FAIL reset_tdata: got %h want 0", outbound_tdata); end
    vectors++;
    if (o_frame_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_frames: got %0d want 0", o_frame_count); end
    vectors++;
    if (o_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_idle: got %0b want 1", o_idle); end
    vectors++;
    if (inbound_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tready_low: got %0b want 0", inbound_tready); end
    @(negedge clk);
    rstn = 1'b1;
    #4;
    vectors++;
    if (inbound_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tready_after: got %0b want 1", inbound_tready); end
  endtask

  task automatic test_back_to_back();
    outbound_tready = 1'b1;
    hsCycles.delete();
    for (int i = 0; i < 8; i++) begin
      sendBeat(W'(i), ((i % MB) == MB - 1), 1'b0);
    end
    idleInput();
    waitDrain(50);
    expFrames += 2;
    vectors++;
    if (hsCycles.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d beats want 8", hsCycles.size());
    end else begin
      vectors++;
      if (hsCycles[7] - hsCycles[0] != 7) begin
        miscompares++;
        $display("[TB] FAIL b2b_throughput: got span %0d cycles want 7", hsCycles[7] - hsCycles[0]);
      end
    end
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL b2b_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  task automatic test_timeout();
    int firstK;
    firstK = -1;
    outbound_tready = 1'b1;
    sendBeat(W'(8'hA5), 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      inbound_tvalid = 1'b0;
      #4;
      if (outbound_tvalid === 1'b1) begin
        firstK = k;
        break;
      end
    end
    vectors++;
    if (firstK != TO + 2) begin miscompares++; $display("[TB] FAIL timeout_latency: got %0d cycles want %0d", firstK, TO + 2); end
    @(negedge clk);
    #4;
    expFrames += 1;
    vectors++;
    if (o_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_idle: got %0b want 1", o_idle); end
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL timeout_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  task automatic test_flush();
    outbound_tready = 1'b1;
    sendBeat(W'(8'h11), 1'b0, 1'b0);
    sendBeat(W'(8'h22), 1'b1, 1'b0);
    idleInput();
    repeat (2) @(negedge clk);
    #4;
    vectors++;
    if (outbound_tvalid !== 1'b0 || o_idle !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_held: got valid=%0b idle=%0b want valid=0 idle=0", outbound_tvalid, o_idle);
    end
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    waitDrain(20);
    expFrames += 1;
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL flush_frames: got %0d want %0d", o_frame_count, expFrames); end
    // A flush with nothing held must not produce a beat.
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      vectors++;
      if (outbound_tvalid !== 1'b0 || o_idle !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL idle_flush: got valid=%0b idle=%0b want valid=0 idle=1", outbound_tvalid, o_idle);
      end
      @(negedge clk);
    end
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL idle_flush_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  task automatic test_flush_coincident();
    outbound_tready = 1'b1;
    sendBeat(W'(8'h31), 1'b1, 1'b0);
    sendBeat(W'(8'h32), 1'b0, 1'b1);
    sendBeat(W'(8'h33), 1'b0, 1'b0);
    sendBeat(W'(8'h34), 1'b0, 1'b0);
    sendBeat(W'(8'h35), 1'b1, 1'b0);
    idleInput();
    waitDrain(50);
    expFrames += 2;
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL coincident_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  task automatic test_random_stall();
    logic [W-1:0] d;
    int gap;
    stopRand = 1'b0;
    fork
      begin
        forever begin
          @(negedge clk);
          if (stopRand) break;
          outbound_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idleInput();
        repeat (gap - 1) @(negedge clk);
      end
      d = {$urandom(), $urandom(), $urandom(), 32'(i)};
      sendBeat(d, ((i % MB) == MB - 1), 1'b0);
    end
    idleInput();
    stopRand = 1'b1;
    @(negedge clk);
    outbound_tready = 1'b1;
    waitDrain(200);
    expFrames += 200 / MB;
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL random_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  task automatic test_reset_mid_frame();
    outbound_tready = 1'b0;
    sendBeat(W'(8'h41), 1'b0, 1'b0);
    sendBeat(W'(8'h42), 1'b0, 1'b0);
    @(negedge clk);
    inbound_tdata  = W'(8'h43);
    inbound_tvalid = 1'b1;
    #4;
    vectors++;
    if (inbound_tready !== 1'b0 || outbound_tvalid !== 1'b1 || o_idle !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_full: got tready=%0b valid=%0b idle=%0b want 0 1 0", inbound_tready, outbound_tvalid, o_idle);
    end
    #3;
    rstn = 1'b0;
    #1;
    sb.delete();
    expFrames = 0;
    vectors++;
    if (outbound_tvalid !== 1'b0 || outbound_tlast !== 1'b0 || outbound_tdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_out: got valid=%0b last=%0b data=%h want 0 0 0", outbound_tvalid, outbound_tlast, outbound_tdata);
    end
    vectors++;
    if (o_frame_count !== 16'd0 || o_idle !== 1'b1 || inbound_tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_status: got frames=%0d idle=%0b tready=%0b want 0 1 0", o_frame_count, o_idle, inbound_tready);
    end
    @(negedge clk);
    inbound_tvalid  = 1'b0;
    outbound_tready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sendBeat(W'(8'h51 + i), (i == 3), 1'b0);
    end
    idleInput();
    waitDrain(50);
    expFrames += 1;
    vectors++;
    if (o_frame_count !== 16'(expFrames)) begin miscompares++; $display("[TB] FAIL post_reset_frames: got %0d want %0d", o_frame_count, expFrames); end
  endtask

  initial begin
    $display("[TB] nx_stream_framer bench start");
    test_reset();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_flush_coincident();
    test_random_stall();
    test_reset_mid_frame();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL leftover_beats: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nx_stream_framer.md
# nx_stream_framer

Host-side framer for the Nexus outbound control stream. Nexus emits control responses as a bare valid/ready stream with no frame boundaries. This block sits between that stream and the FPGA's AXI4-stream DMA. It regenerates `tlast` so the DMA sees bounded frames: a frame closes on a maximum beat count, on an idle timeout, or on an explicit flush.

## Interface
- `AXI4_DATA_WIDTH`, 128: stream data width.
- `MAX_BEATS`, 16: maximum beats per frame, ≥1.
- `TIMEOUT`, 256: consecutive input-idle cycles, with a pending beat, before the frame is closed; ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `inbound_tdata` in `AXI4_DATA_WIDTH`: beat data from Nexus.
- `inbound_tvalid` in 1: beat valid from Nexus.
- `inbound_tready` out 1: block accepts the beat.
- `i_flush` in 1: single-cycle request to close the open frame.
- `outbound_tdata` out `AXI4_DATA_WIDTH`: beat data to the DMA.
- `outbound_tlast` out 1: final beat of the frame.
- `outbound_tvalid` out 1: output beat valid.
- `outbound_tready` in 1: DMA accepts the beat.
- `o_idle` out 1: hold stage and output stage both empty.
- `o_frame_count` out 16: frames completed on outbound; wraps 0xFFFF→0.

## Operation
- Two registered stages: hold (H: valid, data) and output (O: valid, data, last).
- Input handshake: a beat is captured into H when `inbound_tvalid & inbound_tready`.
- `inbound_tready = !H.valid | release`. It is combinational and forced to 0 while `rstn` is low.
- `can_load = !O.valid | outbound_tready`.
- Release of H into O requires `H.valid & can_load` plus one of the following conditions. The conditions are listed in priority order, and only the first that applies sets `last`:
  - `beat_cnt == MAX_BEATS-1` → `last=1`.
  - `i_flush` → `last=1`.
  - `idle_cnt == TIMEOUT` → `last=1`.
  - `inbound_tvalid` → `last=0`.
- `beat_cnt` (width `$clog2(MAX_BEATS)`, minimum 1) counts beats released in the current frame:
  - increments on release with `last=0`;
  - clears on release with `last=1`.
- `idle_cnt`:
  - clears when H is empty or `inbound_tvalid` is high;
  - otherwise increments, saturating at `TIMEOUT`.
- Invariant: H empty ⇒ no open frame. While H is empty, `i_flush` and the timeout have no effect. An O beat already loaded is never modified.
- If a release would occur but `can_load` is low (DMA stalled):
  - H holds its data;
  - `inbound_tready` is 0;
  - the release occurs on the first cycle `can_load` is high, with the condition re-evaluated on that cycle. A flush pulse seen during the stall is not remembered.
- O clears its valid on `outbound_tready` when it is not being reloaded.
- `o_frame_count` increments on `outbound_tvalid & outbound_tready & outbound_tlast`.
- `o_idle = !H.valid & !O.valid`.

## Timing
- Reset values: `outbound_tvalid=0`, `outbound_tlast=0`, `outbound_tdata=0`, `o_frame_count=0`, `o_idle=1`; `inbound_tready=0` during reset and 1 on the first cycle after release. Internal counters reset to 0.
- Reset mid-frame discards H and O contents immediately. No partial frame is completed.
- Latency from input acceptance at edge N to `outbound_tvalid`:
  - edge N+2 at minimum, when a release condition holds in cycle N+1;
  - `MAX_BEATS=1`: always N+2.
- Timeout close: a lone beat accepted at edge N appears with `tlast=1` at edge N+TIMEOUT+2, given `outbound_tready` high.
- Throughput: one beat per cycle sustained, with continuous `inbound_tvalid` and `outbound_tready`.
- Flush in the same cycle as `inbound_tvalid`: H releases with `last=1`, and the new beat is captured as the first beat of the next frame.
- AXI rule: once `outbound_tvalid` is asserted, `outbound_tdata` and `outbound_tlast` stay stable until `outbound_tready`.

## Test plan
- `MAX_BEATS=4`, `TIMEOUT=8`; stream 8 back-to-back beats 0..7 with `outbound_tready=1` → outbound carries 0..7 on 8 consecutive cycles, `tlast` on beats 3 and 7, `o_frame_count=2`.
- Single beat 0xA5 then idle → it emerges 10 cycles after acceptance with `tlast=1`, and `o_idle=1` after the handshake.
- 2 beats, then `i_flush` while the second is held → second beat emerges with `tlast=1`. A flush with the block idle produces no output.
- Random `outbound_tready` (50%) over 200 beats → data order preserved, no beat lost or duplicated, `tlast` every ≤4 beats, outputs stable during stalls.
- Flush coincident with a new input beat → held beat closes with `tlast=1`, and the new beat starts the next frame with `beat_cnt` restarted.
- Assert `rstn` low mid-frame with H and O full → outputs reach reset values asynchronously, and the next stream starts a fresh frame with `o_frame_count=0`.
